// File: rtl/anc_ctrl_pkg.sv
// Shared definitions for the multi-channel ANC update controller.
//   state_t  : controller FSM states (2-bit encoding)
//   DEF_W    : default sample / step-size width
//   DEF_FRAC : default number of fractional bits in the step size
//   DEF_RND  : round-half-up bias for the default fractional width
package anc_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      WAIT = 2'd2,
      EMIT = 2'd3
   } state_t;

   localparam int DEF_W    = 16;
   localparam int DEF_FRAC = 15;
   localparam int DEF_RND  = 1 << (DEF_FRAC - 1);

endpackage

// File: rtl/anc_sat_mult.sv
// Combinational weight-adjust datapath: adj = sat(((e - a) * u + 2^(FRAC-1)) >>> FRAC).
// Ports:
//   e_i   [W-1:0]  error sample (signed)
//   a_i   [W-1:0]  anti-noise sample (signed)
//   u_i   [W-1:0]  step size, FRAC fractional bits (signed)
//   adj_o [W-1:0]  rounded, saturated adjustment (signed)
module anc_sat_mult #(
   parameter int W    = 16,
   parameter int FRAC = 15
) (
   input  logic [W-1:0] e_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] u_i,
   output logic [W-1:0] adj_o
);

   localparam int PW = 2 * W + 1;
   localparam logic signed [PW-1:0] ONE     = {{(PW - 1){1'b0}}, 1'b1};
   localparam logic signed [PW-1:0] RND     = ONE <<< (FRAC - 1);
   localparam logic signed [PW-1:0] SAT_MAX = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};

   logic signed [W:0]    diff_s;
   logic signed [PW-1:0] diff_x_s;
   logic signed [PW-1:0] u_x_s;
   logic signed [PW-1:0] prod_s;
   logic signed [PW-1:0] shr_s;

   // Widened difference and product cannot overflow; clamp after the rounding shift.
   always_comb begin
      diff_s   = $signed({e_i[W-1], e_i}) - $signed({a_i[W-1], a_i});
      diff_x_s = {{W{diff_s[W]}}, diff_s};
      u_x_s    = {{(W + 1){u_i[W-1]}}, u_i};
      prod_s   = diff_x_s * u_x_s;
      shr_s    = (prod_s + RND) >>> FRAC;
      if (shr_s > SAT_MAX) begin
         adj_o = SAT_MAX[W-1:0];
      end else if (shr_s < SAT_MIN) begin
         adj_o = SAT_MIN[W-1:0];
      end else begin
         adj_o = shr_s[W-1:0];
      end
   end

endmodule

// File: rtl/anc_controller_mc.sv
// Multi-channel ANC update controller. Latches one frame of per-channel
// samples, then for each channel 0..CH-1 computes the weight adjustment,
// pulses the shared FIR engine, waits for completion (bounded by TIMEOUT)
// and hands the result downstream over a valid/ready port.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid / in_ready          frame handshake
//   e_in, x_in, a_in [W*CH]      per-channel samples, ch k at [k*W +: W]
//   u_in [W]                     step size
//   fir_go, fir_ch, x_out,
//   weight_adjust                FIR launch interface
//   fir_done, fir_out [2W]       FIR completion interface
//   out_valid / out_ready,
//   out_sample [2W], out_ch      result port
//   timeout_err                  sticky FIR timeout flag
module anc_controller_mc
   import anc_ctrl_pkg::*;
#(
   parameter int W       = DEF_W,
   parameter int FRAC    = DEF_FRAC,
   parameter int CH      = 4,
   parameter int CHW     = (CH > 1) ? $clog2(CH) : 1,
   parameter int TIMEOUT = 1023,
   parameter int TW      = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W*CH-1:0]   e_in,
   input  logic [W*CH-1:0]   x_in,
   input  logic [W*CH-1:0]   a_in,
   input  logic [W-1:0]      u_in,
   output logic              fir_go,
   output logic [CHW-1:0]    fir_ch,
   output logic [W-1:0]      x_out,
   output logic [W-1:0]      weight_adjust,
   input  logic              fir_done,
   input  logic [2*W-1:0]    fir_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*W-1:0]    out_sample,
   output logic [CHW-1:0]    out_ch,
   output logic              timeout_err
);

   state_t              state_q, state_d;
   logic [CHW-1:0]      k_q, k_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic [W*CH-1:0]     e_q, e_d, x_q, x_d, a_q, a_d;
   logic [W-1:0]        u_q, u_d;
   logic                in_ready_q, in_ready_d;
   logic                fir_go_q, fir_go_d;
   logic [CHW-1:0]      fir_ch_q, fir_ch_d;
   logic [W-1:0]        x_out_q, x_out_d;
   logic [W-1:0]        wadj_q, wadj_d;
   logic                out_valid_q, out_valid_d;
   logic [2*W-1:0]      out_sample_q, out_sample_d;
   logic [CHW-1:0]      out_ch_q, out_ch_d;
   logic                terr_q, terr_d;

   logic [W-1:0]        e_sel_s, x_sel_s, a_sel_s, adj_s;
   logic                last_ch_s;

   assign e_sel_s   = e_q[W*int'(k_q) +: W];
   assign x_sel_s   = x_q[W*int'(k_q) +: W];
   assign a_sel_s   = a_q[W*int'(k_q) +: W];
   assign last_ch_s = (k_q == CHW'(CH - 1));

   anc_sat_mult #(.W(W), .FRAC(FRAC)) u_sat_mult (
      .e_i   (e_sel_s),
      .a_i   (a_sel_s),
      .u_i   (u_q),
      .adj_o (adj_s)
   );

   // Next-state and output-register logic for the channel sequencer.
   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      tmo_d        = tmo_q;
      e_d          = e_q;
      x_d          = x_q;
      a_d          = a_q;
      u_d          = u_q;
      fir_go_d     = 1'b0;   // never held: a pulse only on leaving CALC
      fir_ch_d     = fir_ch_q;
      x_out_d      = x_out_q;
      wadj_d       = wadj_q;
      out_valid_d  = out_valid_q;
      out_sample_d = out_sample_q;
      out_ch_d     = out_ch_q;
      terr_d       = terr_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               e_d     = e_in;
               x_d     = x_in;
               a_d     = a_in;
               u_d     = u_in;
               k_d     = '0;
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            x_out_d  = x_sel_s;
            fir_ch_d = k_q;
            wadj_d   = adj_s;
            fir_go_d = 1'b1;
            tmo_d    = '0;
            state_d  = WAIT;
         end
         WAIT: begin
            if (fir_done) begin
               out_sample_d = fir_out;
               out_ch_d     = k_q;
               out_valid_d  = 1'b1;
               state_d      = EMIT;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               // This is the TIMEOUT-th cycle spent waiting.
               tmo_d        = tmo_q + TW'(1);
               out_sample_d = '0;
               out_ch_d     = k_q;
               out_valid_d  = 1'b1;
               terr_d       = 1'b1;
               state_d      = EMIT;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         EMIT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (last_ch_s) begin
                  state_d = IDLE;
               end else begin
                  k_d     = k_q + CHW'(1);
                  state_d = CALC;
               end
            end else begin
               state_d = EMIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d = (state_d == IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         k_q          <= '0;
         tmo_q        <= '0;
         e_q          <= '0;
         x_q          <= '0;
         a_q          <= '0;
         u_q          <= '0;
         in_ready_q   <= 1'b1;
         fir_go_q     <= 1'b0;
         fir_ch_q     <= '0;
         x_out_q      <= '0;
         wadj_q       <= '0;
         out_valid_q  <= 1'b0;
         out_sample_q <= '0;
         out_ch_q     <= '0;
         terr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         tmo_q        <= tmo_d;
         e_q          <= e_d;
         x_q          <= x_d;
         a_q          <= a_d;
         u_q          <= u_d;
         in_ready_q   <= in_ready_d;
         fir_go_q     <= fir_go_d;
         fir_ch_q     <= fir_ch_d;
         x_out_q      <= x_out_d;
         wadj_q       <= wadj_d;
         out_valid_q  <= out_valid_d;
         out_sample_q <= out_sample_d;
         out_ch_q     <= out_ch_d;
         terr_q       <= terr_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign fir_go        = fir_go_q;
   assign fir_ch        = fir_ch_q;
   assign x_out         = x_out_q;
   assign weight_adjust = wadj_q;
   assign out_valid     = out_valid_q;
   assign out_sample    = out_sample_q;
   assign out_ch        = out_ch_q;
   assign timeout_err   = terr_q;

endmodule
